// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - instruction fetch with one-entry prefetch buffer and IR field decode
module fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_ir,
    input  logic        load_pc,
    input  logic        clear_pc,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_stall,
    output logic        ir_valid,
    output logic [31:0] pc_ir,
    output logic [3:0]  cond,
    output logic [6:0]  opcode,
    output logic [3:0]  rn,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic [3:0]  rm,
    output logic [1:0]  shift_op,
    output logic [31:0] shift_imme,
    output logic [31:0] imme_data
);

    typedef enum logic [1:0] {IDLE, FETCH, FULL, DROP} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] buf_data;
    logic [31:0] buf_pc;
    logic [31:0] ir;
    logic        pending_load;
    logic        redirect;
    logic [31:0] redirect_pc;

    assign redirect    = (clear_pc | load_pc) && (state != IDLE);
    assign redirect_pc = clear_pc ? RESET_PC : branch_target;

    assign imem_req    = (state == FETCH);
    assign imem_addr   = fetch_pc;
    assign fetch_stall = pending_load | (load_ir && (state != FULL) && !redirect);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            buf_data     <= 32'h0;
            buf_pc       <= 32'h0;
            ir           <= 32'h0;
            pc_ir        <= 32'h0;
            ir_valid     <= 1'b0;
            pending_load <= 1'b0;
        end else if (state == IDLE) begin
            state <= FETCH;
        end else if (redirect) begin
            // A request still awaiting its response must have that response swallowed in DROP.
            fetch_pc     <= redirect_pc;
            pending_load <= 1'b0;
            state        <= ((state == FETCH || state == DROP) && !imem_valid) ? DROP : FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_valid) begin
                        fetch_pc <= fetch_pc + PC_STEP;
                        if (pending_load || load_ir) begin
                            ir           <= imem_rdata;
                            pc_ir        <= fetch_pc;
                            ir_valid     <= 1'b1;
                            pending_load <= 1'b0;
                        end else begin
                            buf_data <= imem_rdata;
                            buf_pc   <= fetch_pc;
                            state    <= FULL;
                        end
                    end else if (load_ir) begin
                        pending_load <= 1'b1;
                    end
                end
                FULL: begin
                    if (load_ir) begin
                        ir       <= buf_data;
                        pc_ir    <= buf_pc;
                        ir_valid <= 1'b1;
                        state    <= FETCH;
                    end
                end
                DROP: begin
                    if (imem_valid) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Bits 20 and 4 carry no meaning for the controller.
    logic unused_ir_bits;
    assign unused_ir_bits = ir[20] ^ ir[4];

    assign cond       = ir[31:28];
    assign opcode     = ir[27:21];
    assign rn         = ir[19:16];
    assign rd         = ir[15:12];
    assign rs         = ir[11:8];
    assign rm         = ir[3:0];
    assign shift_op   = ir[6:5];
    assign shift_imme = {27'h0, ir[11:7]};
    assign imme_data  = {20'h0, ir[11:0]};

endmodule
